// File: rtl/scene_pkg.sv
// Shared phase codes, default scene timing and RGB channel helpers for the
// scene scheduler and its pixel compositor.
package scene_pkg;

  typedef enum logic [1:0] {
    PH_INTRO  = 2'd0,
    PH_SCROLL = 2'd1,
    PH_HOLD   = 2'd2,
    PH_FADE   = 2'd3
  } phase_t;

  localparam int DEF_V_ACTIVE      = 480;
  localparam int DEF_H_ACTIVE      = 640;
  localparam int DEF_INTRO_FRAMES  = 60;
  localparam int DEF_SCROLL_FRAMES = 240;
  localparam int DEF_HOLD_FRAMES   = 120;
  localparam int DEF_FADE_DIV      = 8;

  function automatic logic [1:0] ch_r(input logic [5:0] p);
    return p[5:4];
  endfunction

  function automatic logic [1:0] ch_g(input logic [5:0] p);
    return p[3:2];
  endfunction

  function automatic logic [1:0] ch_b(input logic [5:0] p);
    return p[1:0];
  endfunction

  // Channel darkening saturates at black instead of wrapping.
  function automatic logic [1:0] sat_sub(input logic [1:0] c, input logic [1:0] d);
    return (c > d) ? (c - d) : 2'd0;
  endfunction

endpackage

// File: rtl/scene_scheduler_fade_mux.sv
// Combinational compositor: picks background or overlay, darkens by the fade
// level and blanks outside the visible region. Registered by the parent.
module fade_mux
  import scene_pkg::*;
(
  input  logic [1:0] phase,
  input  logic [1:0] fade_level,
  input  logic       frame_active,
  input  logic [5:0] bg_rgb,
  input  logic [5:0] overlay_rgb,
  input  logic       overlay_active,
  output logic [5:0] pix
);

  logic [5:0] src;

  always_comb begin
    // The overlay stays hidden for the whole INTRO phase.
    src = (overlay_active && (phase != PH_INTRO)) ? overlay_rgb : bg_rgb;
    pix = 6'd0;
    if (frame_active) begin
      pix = {sat_sub(ch_r(src), fade_level),
             sat_sub(ch_g(src), fade_level),
             sat_sub(ch_b(src), fade_level)};
    end
  end

endmodule

// File: rtl/scene_scheduler.sv
// Frame-level scene sequencer: INTRO/SCROLL/HOLD/FADE phase machine advanced
// once per frame, scroll/fade config generation and a registered pixel output.
module scene_scheduler
  import scene_pkg::*;
#(
  parameter int V_ACTIVE      = DEF_V_ACTIVE,
  parameter int H_ACTIVE      = DEF_H_ACTIVE,
  parameter int INTRO_FRAMES  = DEF_INTRO_FRAMES,
  parameter int SCROLL_FRAMES = DEF_SCROLL_FRAMES,
  parameter int HOLD_FRAMES   = DEF_HOLD_FRAMES,
  parameter int FADE_DIV      = DEF_FADE_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       frame_active,
  input  logic       pause,
  input  logic       skip,
  input  logic [5:0] bg_rgb,
  input  logic [5:0] overlay_rgb,
  input  logic       overlay_active,
  output logic [5:0] rgb,
  output logic [9:0] scroll_x,
  output logic [9:0] scroll_y,
  output logic [1:0] phase,
  output logic [1:0] fade_level
);

  // rgb carries no handshake: it is valid every cycle and reflects the pixel
  // inputs sampled on the previous clock edge.
  phase_t     state, state_next;
  logic [7:0] pcnt, pcnt_next;
  logic [9:0] sx, sx_next;
  logic [1:0] fade, fade_next;
  logic       skip_pend, skip_pend_next;
  logic [7:0] phase_last;
  logic [10:0] sx_inc;
  logic       frame_tick;
  logic [5:0] pix, rgb_q;

  assign frame_tick = (x == 10'd0) && (y == 10'(V_ACTIVE));
  assign sx_inc     = {1'b0, sx} + 11'd1;

  always_comb begin
    phase_last = 8'(INTRO_FRAMES - 1);
    case (state)
      PH_INTRO:  phase_last = 8'(INTRO_FRAMES - 1);
      PH_SCROLL: phase_last = 8'(SCROLL_FRAMES - 1);
      PH_HOLD:   phase_last = 8'(HOLD_FRAMES - 1);
      PH_FADE:   phase_last = 8'(4 * FADE_DIV - 1);
      default:   phase_last = 8'(INTRO_FRAMES - 1);
    endcase
  end

  always_comb begin
    state_next     = state;
    pcnt_next      = pcnt;
    sx_next        = sx;
    fade_next      = fade;
    skip_pend_next = skip_pend | skip;
    if (frame_tick) begin
      skip_pend_next = 1'b0;
      if (skip_pend || skip) begin
        // A pending skip overrides pause and the normal count.
        state_next = phase_t'(state + 2'd1);
        pcnt_next  = 8'd0;
      end else if (!pause) begin
        if (state == PH_SCROLL) begin
          sx_next = (sx_inc == 11'(H_ACTIVE)) ? 10'd0 : sx_inc[9:0];
        end
        if (pcnt == phase_last) begin
          state_next = phase_t'(state + 2'd1);
          pcnt_next  = 8'd0;
        end else begin
          pcnt_next = pcnt + 8'd1;
        end
      end
      if (state_next == PH_INTRO) begin
        sx_next   = 10'd0;
        fade_next = 2'd0;
      end else if (state_next == PH_FADE) begin
        // Step thresholds instead of a divide: level = pcnt / FADE_DIV.
        if (pcnt_next >= 8'(3 * FADE_DIV))      fade_next = 2'd3;
        else if (pcnt_next >= 8'(2 * FADE_DIV)) fade_next = 2'd2;
        else if (pcnt_next >= 8'(FADE_DIV))     fade_next = 2'd1;
        else                                    fade_next = 2'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PH_INTRO;
      pcnt      <= 8'd0;
      sx        <= 10'd0;
      fade      <= 2'd0;
      skip_pend <= 1'b0;
      rgb_q     <= 6'd0;
    end else begin
      state     <= state_next;
      pcnt      <= pcnt_next;
      sx        <= sx_next;
      fade      <= fade_next;
      skip_pend <= skip_pend_next;
      rgb_q     <= pix;
    end
  end

  fade_mux u_fade_mux (
    .phase          (state),
    .fade_level     (fade),
    .frame_active   (frame_active),
    .bg_rgb         (bg_rgb),
    .overlay_rgb    (overlay_rgb),
    .overlay_active (overlay_active),
    .pix            (pix)
  );

  assign rgb        = rgb_q;
  assign scroll_x   = sx;
  assign scroll_y   = 10'd0;
  assign phase      = state;
  assign fade_level = fade;

endmodule

// File: tb/tb_scene_scheduler.sv
// Directed scoreboard bench for scene_scheduler using short phase lengths
// (INTRO=2, SCROLL=3, HOLD=2, FADE_DIV=1, H_ACTIVE=2).
module tb_scene_scheduler;

  logic       clk;
  logic       rst;
  logic [9:0] x, y;
  logic       frame_active, pause, skip, overlay_active;
  logic [5:0] bg_rgb, overlay_rgb;
  logic [5:0] rgb;
  logic [9:0] scroll_x, scroll_y;
  logic [1:0] phase, fade_level;

  scene_scheduler #(
    .V_ACTIVE(480), .H_ACTIVE(2), .INTRO_FRAMES(2),
    .SCROLL_FRAMES(3), .HOLD_FRAMES(2), .FADE_DIV(1)
  ) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .frame_active(frame_active),
    .pause(pause), .skip(skip), .bg_rgb(bg_rgb), .overlay_rgb(overlay_rgb),
    .overlay_active(overlay_active), .rgb(rgb), .scroll_x(scroll_x),
    .scroll_y(scroll_y), .phase(phase), .fade_level(fade_level)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    int         kind;
    logic [9:0] val;
    int         due;
  } exp_t;

  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  string kname[5] = '{"rgb", "phase", "scroll_x", "fade_level", "scroll_y"};

  logic [1:0] e_phase;
  logic [9:0] e_sx;
  logic [1:0] e_fade;
  logic       cur_pause;

  always @(negedge clk) begin
    exp_t       e;
    logic [9:0] act;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      case (e.kind)
        0:       act = {4'b0, rgb};
        1:       act = {8'b0, phase};
        2:       act = scroll_x;
        3:       act = {8'b0, fade_level};
        default: act = scroll_y;
      endcase
      checks++;
      if (act !== e.val || e.due != cyc) begin
        errors++;
        $display("FAIL %s cycle %0d got %0h expected %0h", kname[e.kind], cyc, act, e.val);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input int kind, input logic [9:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.due  = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [9:0] xi, input logic [9:0] yi, input logic fa,
                      input logic oa, input logic sk, input logic rs,
                      input logic [5:0] bg, input logic [5:0] ov, input logic [5:0] exp_rgb);
    @(posedge clk);
    #1;
    x = xi; y = yi; frame_active = fa; overlay_active = oa;
    skip = sk; rst = rs; bg_rgb = bg; overlay_rgb = ov; pause = cur_pause;
    push(0, {4'b0, exp_rgb});
    push(1, {8'b0, e_phase});
    push(2, e_sx);
    push(3, {8'b0, e_fade});
    push(4, 10'd0);
  endtask

  task automatic tick(input logic sk, input logic [1:0] ph, input logic [9:0] sx,
                      input logic [1:0] fd);
    e_phase = ph; e_sx = sx; e_fade = fd;
    step(10'd0, 10'd480, 1'b0, 1'b1, sk, 1'b0, 6'h3f, 6'h3f, 6'd0);
  endtask

  task automatic pix(input logic fa, input logic oa, input logic sk,
                     input logic [5:0] bg, input logic [5:0] ov, input logic [5:0] exp_rgb);
    step(10'd5, 10'd10, fa, oa, sk, 1'b0, bg, ov, exp_rgb);
  endtask

  task automatic reset_step();
    e_phase = 2'd0; e_sx = 10'd0; e_fade = 2'd0;
    step(10'd123, 10'd45, 1'b1, 1'b1, 1'b0, 1'b1, 6'h3f, 6'h3f, 6'd0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; x = 10'd0; y = 10'd0; frame_active = 1'b0; pause = 1'b0;
    skip = 1'b0; bg_rgb = 6'd0; overlay_rgb = 6'd0; overlay_active = 1'b0;
    cur_pause = 1'b0;
    e_phase = 2'd0; e_sx = 10'd0; e_fade = 2'd0;

    reset_step();
    reset_step();

    // INTRO: background passes through, overlay suppressed, blanking
    pix(1'b1, 1'b1, 1'b0, 6'b100111, 6'b111111, 6'b100111);
    pix(1'b1, 1'b0, 1'b0, 6'b010010, 6'b001100, 6'b010010);
    pix(1'b0, 1'b0, 1'b0, 6'h3f, 6'h3f, 6'd0);

    // Full scene cycle
    tick(1'b0, 2'd0, 10'd0, 2'd0);
    tick(1'b0, 2'd1, 10'd0, 2'd0);
    pix(1'b1, 1'b1, 1'b0, 6'b000001, 6'b110110, 6'b110110);
    step(10'd0, 10'd479, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000001, 6'h3f, 6'b000001);
    step(10'd1, 10'd480, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000010, 6'h3f, 6'b000010);
    tick(1'b0, 2'd1, 10'd1, 2'd0);
    tick(1'b0, 2'd1, 10'd0, 2'd0);
    tick(1'b0, 2'd2, 10'd1, 2'd0);
    pix(1'b1, 1'b1, 1'b0, 6'b000000, 6'b011011, 6'b011011);
    tick(1'b0, 2'd2, 10'd1, 2'd0);
    tick(1'b0, 2'd3, 10'd1, 2'd0);
    pix(1'b1, 1'b0, 1'b0, 6'b101101, 6'h3f, 6'b101101);
    tick(1'b0, 2'd3, 10'd1, 2'd1);
    pix(1'b1, 1'b0, 1'b0, 6'b101101, 6'h3f, 6'b011000);
    tick(1'b0, 2'd3, 10'd1, 2'd2);
    pix(1'b1, 1'b1, 1'b0, 6'b111111, 6'b110110, 6'b010000);
    pix(1'b0, 1'b1, 1'b0, 6'b111111, 6'b110110, 6'd0);
    tick(1'b0, 2'd3, 10'd1, 2'd3);
    pix(1'b1, 1'b1, 1'b0, 6'b111111, 6'b111111, 6'd0);
    tick(1'b0, 2'd0, 10'd0, 2'd0);
    pix(1'b1, 1'b1, 1'b0, 6'b001001, 6'b111111, 6'b001001);

    // Into SCROLL, then pause for five ticks
    tick(1'b0, 2'd0, 10'd0, 2'd0);
    tick(1'b0, 2'd1, 10'd0, 2'd0);
    tick(1'b0, 2'd1, 10'd1, 2'd0);
    cur_pause = 1'b1;
    for (int i = 0; i < 5; i++) tick(1'b0, 2'd1, 10'd1, 2'd0);
    cur_pause = 1'b0;
    tick(1'b0, 2'd1, 10'd0, 2'd0);
    tick(1'b0, 2'd2, 10'd1, 2'd0);

    // HOLD: two skips during pause give exactly one advance with pcnt cleared
    tick(1'b0, 2'd2, 10'd1, 2'd0);
    cur_pause = 1'b1;
    pix(1'b1, 1'b0, 1'b1, 6'b010101, 6'h00, 6'b010101);
    pix(1'b1, 1'b0, 1'b1, 6'b010101, 6'h00, 6'b010101);
    tick(1'b0, 2'd3, 10'd1, 2'd0);
    tick(1'b0, 2'd3, 10'd1, 2'd0);
    cur_pause = 1'b0;
    tick(1'b0, 2'd3, 10'd1, 2'd1);

    // Skip coincident with the frame tick
    tick(1'b1, 2'd0, 10'd0, 2'd0);
    tick(1'b0, 2'd0, 10'd0, 2'd0);
    tick(1'b1, 2'd1, 10'd0, 2'd0);
    tick(1'b0, 2'd1, 10'd1, 2'd0);
    tick(1'b0, 2'd1, 10'd0, 2'd0);
    tick(1'b0, 2'd2, 10'd1, 2'd0);

    // Reset mid-HOLD with a skip pending; scene restarts cleanly
    pix(1'b1, 1'b0, 1'b1, 6'b110011, 6'h00, 6'b110011);
    reset_step();
    tick(1'b0, 2'd0, 10'd0, 2'd0);
    tick(1'b0, 2'd1, 10'd0, 2'd0);
    tick(1'b0, 2'd1, 10'd1, 2'd0);
    pix(1'b1, 1'b0, 1'b0, 6'b100100, 6'h00, 6'b100100);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors += exp_q.size();
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scene_scheduler.md
# scene_scheduler

Frame-level sequencer for the graphics engine. Runs a four-phase scene state machine (INTRO, SCROLL, HOLD, FADE) advanced once per frame, drives the scroll configuration consumed by the overlay creator, and arbitrates each pixel between the background layer and the overlay layer. It applies a fade to the result and emits a registered 6-bit RGB word to the VGA output stage.

## Interface

Parameters:
- V_ACTIVE, 480, visible lines; frame tick fires at start of line V_ACTIVE
- H_ACTIVE, 640, visible pixels; scroll_x wrap modulus
- INTRO_FRAMES, 60, INTRO phase length in frames (1..255)
- SCROLL_FRAMES, 240, SCROLL phase length (1..255)
- HOLD_FRAMES, 120, HOLD phase length (1..255)
- FADE_DIV, 8, frames per fade step (1..63); FADE length = 4*FADE_DIV

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- x  in  10  current pixel column
- y  in  10  current line
- frame_active  in  1  visible-region flag
- pause  in  1  level; freezes phase and frame counting
- skip  in  1  pulse; request jump to next phase
- bg_rgb  in  6  background pixel {r,g,b} 2 bits each
- overlay_rgb  in  6  overlay pixel
- overlay_active  in  1  overlay covers this pixel
- rgb  out  6  composited pixel, registered
- scroll_x  out  10  horizontal overlay offset
- scroll_y  out  10  vertical overlay offset (constant 0 in this revision; reserved)
- phase  out  2  current phase code
- fade_level  out  2  current fade amount

## Operation

- frame_tick = (x == 0) && (y == V_ACTIVE); one cycle per frame. All config state (phase, phase counter, scroll_x, fade_level) changes only on frame_tick, so config is stable across the visible frame.
- Phase counter pcnt (8 bits) counts frames within the phase. On tick with pause low: if pcnt == len-1, advance phase and clear pcnt; else pcnt+1.
- Transitions: INTRO→SCROLL→HOLD→FADE→INTRO. Entering INTRO clears scroll_x and fade_level.
- SCROLL: each counted tick, scroll_x = (scroll_x+1 == H_ACTIVE) ? 0 : scroll_x+1. HOLD and FADE: scroll_x frozen.
- FADE: fade_level = pcnt / FADE_DIV, range 0..3. Updated on the same tick as pcnt.
- skip: a cycle-level pulse sets skip_pend. On the next tick, skip_pend advances phase and clears pcnt regardless of pause, then clears itself. skip_pend is cleared only by that tick or by reset; multiple pulses before a tick produce one advance.
- Pause held: no counting or scrolling; a pending skip still applies.
- Pixel select: src = (overlay_active && phase != INTRO) ? overlay_rgb : bg_rgb.
- Fade: each 2-bit channel c becomes max(c - fade_level, 0), a saturating subtract.
- rgb = frame_active ? faded src : 6'b0.

## Timing

- Reset (rst high at a clk edge): phase=INTRO(0), pcnt=0, scroll_x=0, scroll_y=0, fade_level=0, skip_pend=0, rgb=0. Reset applied mid-frame takes effect at that edge, and the scene restarts at INTRO.
- Pixel path latency: exactly 1 clk from x/y/frame_active/inputs to rgb. No combinational input→output path.
- Config outputs are registered and change on the clk edge that samples frame_tick. Output values become visible in the cycle after the tick.
- Phase codes: INTRO=0, SCROLL=1, HOLD=2, FADE=3.
- When skip arrives in the same cycle as frame_tick, it is applied on that tick: skip_pend OR skip.
- pcnt never exceeds len-1. A length of 1 advances the phase every tick.

## Structure

- Package scene_pkg holds:
  - phase code localparams
  - default frame lengths
  - RGB channel slice helpers
- Sub-module fade_mux is combinational: layer select, saturating fade and frame_active blanking. The register stage lives in scene_scheduler.
- Scheduler FSM and counters live in the top-level body. Target size is roughly 150–250 lines of RTL.

## Test plan

- Reset, then run 2 frames with INTRO_FRAMES=60 → phase=0, scroll_x=0, rgb equals bg_rgb delayed 1 clk, overlay suppressed even with overlay_active=1.
- Use small params INTRO=2, SCROLL=3, HOLD=2, FADE_DIV=1, H_ACTIVE=2 → phase sequence per tick 0,0,1,1,1,2,2,3,3,3,3,0. During SCROLL, scroll_x goes 1,0,1, confirming the wrap.
- In FADE with fade_level=2, input overlay_rgb=6'b11_01_10 with overlay_active=1 → rgb=6'b01_00_00. At level 3 → 0. With frame_active=0 → rgb=0.
- Hold pause high for 5 ticks mid-SCROLL → phase, pcnt and scroll_x unchanged. Then pulse skip twice during pause → one phase advance at the next tick, pcnt=0.
- Pulse skip coincident with frame_tick → advance on that same tick.
- Assert rst mid-HOLD at an arbitrary x,y → next cycle all outputs equal their reset values. Resume from INTRO with scroll_x=0.
